// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the RAM responder
//
// Purpose: word and RAM-state types used on the memory_control <-> RAM
//          boundary, plus the word returned on a rejected request.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - request/response bundle between memory_control and RAM
//
// Purpose: groups the RAM request and response signals.
// Signals:
//   ramREN   read request            (master -> slave)
//   ramWEN   write request           (master -> slave)
//   ramaddr  byte address            (master -> slave)
//   ramstore write data              (master -> slave)
//   ramload  read data               (slave -> master)
//   ramstate FREE/BUSY/ACCESS/ERROR  (slave -> master)
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_responder_ram_array.sv
// rtl/ram_responder_ram_array.sv - word storage for the RAM responder
//
// Purpose: WORDS x 32 storage, combinational read, synchronous write,
//          whole array cleared asynchronously by reset.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low clear of all words
//   i_we     write enable, sampled on i_clk
//   i_addr   word index for both read and write
//   i_wdata  write data
//   o_rdata  read data at i_addr (combinational)
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  word_t         i_wdata,
    output word_t         o_rdata
);

    word_t r_mem [WORDS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - latency-accurate word-addressed RAM model
//
// Purpose: answers memory_control read/write requests after LAT BUSY cycles
//          with one ACCESS cycle; malformed requests get one ERROR cycle.
// Parameters:
//   LAT    wait states before ACCESS (0..15)
//   WORDS  storage depth in 32-bit words (power of two, >= 2)
// Ports:
//   CLK    clock, rising edge
//   nRST   asynchronous active-low reset (also clears storage)
//   ram    ram_responder_if.slave: ramREN/ramWEN/ramaddr/ramstore in,
//          ramload/ramstate out
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int WORDS = 256
) (
    input  logic           CLK,
    input  logic           nRST,
    ram_responder_if.slave ram
);

    localparam int          AW      = $clog2(WORDS);
    localparam int          CW      = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [31:0] WORDS_W = 32'(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        ERR  = 2'd3
    } fsm_t;

    fsm_t          r_state;
    logic [CW-1:0] r_cnt;
    word_t         r_req_addr;
    logic          r_req_wr;

    logic        w_req;
    logic        w_bad;
    logic        w_abort;
    logic        w_we;
    logic [31:0] w_word_idx;
    word_t       w_rdata;

    assign w_req      = ram.ramREN | ram.ramWEN;
    assign w_word_idx = {2'b00, ram.ramaddr[31:2]};

    assign w_bad = (ram.ramREN & ram.ramWEN)
                 | (ram.ramaddr[1:0] != 2'b00)
                 | (w_word_idx >= WORDS_W);

    // The master must hold the exact same request until ACCESS completes;
    // any change (e.g. memory_control switching iaddr -> daddr) cancels it.
    assign w_abort = ~w_req
                   | (ram.ramaddr != r_req_addr)
                   | (ram.ramWEN != r_req_wr)
                   | (ram.ramREN & ram.ramWEN);

    // Commit on the edge ending XFER, and only if the request survived it.
    assign w_we = (r_state == XFER) & r_req_wr & ~w_abort;

    ram_array #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram_array (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_we    (w_we),
        .i_addr  (r_req_addr[AW+1:2]),
        .i_wdata (ram.ramstore),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req_addr <= '0;
            r_req_wr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_bad) begin
                            r_state <= ERR;
                        end else begin
                            r_req_addr <= ram.ramaddr;
                            r_req_wr   <= ram.ramWEN;
                            r_cnt      <= CW'(LAT);
                            r_state    <= (LAT > 0) ? WAIT : XFER;
                        end
                    end
                end
                WAIT: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= XFER;
                        end
                    end
                end
                XFER:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state (and storage addressed by the
    // registered request), never directly on the request inputs.
    always_comb begin
        ram.ramstate = FREE;
        ram.ramload  = '0;
        case (r_state)
            WAIT: ram.ramstate = BUSY;
            XFER: begin
                ram.ramstate = ACCESS;
                if (!r_req_wr) begin
                    ram.ramload = w_rdata;
                end
            end
            ERR: begin
                ram.ramstate = ERROR;
                ram.ramload  = BAD_WORD;
            end
            default: ram.ramstate = FREE;
        endcase
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder (LAT=2 and LAT=0)
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int NDUT = 2;
    localparam int MW   = 256;

    logic  CLK   = 1'b0;
    logic  nRST  = 1'b0;
    logic  ren   = 1'b0;
    logic  wen   = 1'b0;
    word_t addr  = '0;
    word_t store = '0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_responder_if if_a ();
    ram_responder_if if_b ();

    assign if_a.ramREN   = ren;
    assign if_a.ramWEN   = wen;
    assign if_a.ramaddr  = addr;
    assign if_a.ramstore = store;
    assign if_b.ramREN   = ren;
    assign if_b.ramWEN   = wen;
    assign if_b.ramaddr  = addr;
    assign if_b.ramstore = store;

    ram_responder #(.LAT(2), .WORDS(MW)) u_lat2 (.CLK(CLK), .nRST(nRST), .ram(if_a));
    ram_responder #(.LAT(0), .WORDS(MW)) u_lat0 (.CLK(CLK), .nRST(nRST), .ram(if_b));

    ramstate_t act_st [NDUT];
    word_t     act_ld [NDUT];
    assign act_st[0] = if_a.ramstate;
    assign act_ld[0] = if_a.ramload;
    assign act_st[1] = if_b.ramstate;
    assign act_ld[1] = if_b.ramload;

    // Model: ph = 0 free, -1 error cycle, k >= 1 is the k-th cycle after the
    // request was accepted (BUSY while k <= LAT, ACCESS at k = LAT+1).
    int    lat_of [NDUT] = '{2, 0};
    int    ph     [NDUT];
    word_t m_addr [NDUT];
    logic  m_wr   [NDUT];
    word_t mem    [NDUT][MW];

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            ph[d]     = 0;
            m_addr[d] = '0;
            m_wr[d]   = 1'b0;
            for (int i = 0; i < MW; i++) mem[d][i] = '0;
        end
    endtask

    task automatic model_step(int d);
        logic  req;
        word_t a;
        word_t ma;
        req = ren | wen;
        a   = addr;
        ma  = m_addr[d];
        if (ph[d] == 0) begin
            if (req) begin
                if ((ren && wen) || a[1:0] != 2'b00 || a[31:2] >= 30'(MW)) begin
                    ph[d] = -1;
                end else begin
                    m_addr[d] = a;
                    m_wr[d]   = wen;
                    ph[d]     = 1;
                end
            end
        end else if (ph[d] == -1) begin
            ph[d] = 0;
        end else if (!req || a != m_addr[d] || wen != m_wr[d] || (ren && wen)) begin
            ph[d] = 0;
        end else if (ph[d] == lat_of[d] + 1) begin
            if (m_wr[d]) mem[d][ma[9:2]] = store;
            ph[d] = 0;
        end else begin
            ph[d] = ph[d] + 1;
        end
    endtask

    function automatic logic [31:0] exp_state(int d);
        if (ph[d] == 0)  return 32'(FREE);
        if (ph[d] == -1) return 32'(ERROR);
        if (ph[d] <= lat_of[d]) return 32'(BUSY);
        return 32'(ACCESS);
    endfunction

    function automatic word_t exp_load(int d);
        word_t ma;
        ma = m_addr[d];
        if (ph[d] == -1) return 32'hBAD1BAD1;
        if (ph[d] == lat_of[d] + 1 && !m_wr[d]) return mem[d][ma[9:2]];
        return '0;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (nRST) begin
                for (int d = 0; d < NDUT; d++) model_step(d);
            end
        end
    end

    initial forever begin
        @(negedge nRST);
        model_reset();
    end

    initial forever begin
        @(negedge CLK);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("model_state_dut%0d", d), 32'(act_st[d]), exp_state(d));
            check($sformatf("model_load_dut%0d", d), act_ld[d], exp_load(d));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #3;
    endtask

    task automatic drive(logic r, logic w, word_t a, word_t s);
        ren   = r;
        wen   = w;
        addr  = a;
        store = s;
    endtask

    task automatic lit(string nm, int d, ramstate_t st, word_t ld);
        check({nm, "_state"}, 32'(act_st[d]), 32'(st));
        check({nm, "_load"}, act_ld[d], ld);
    endtask

    // Full LAT=2 transaction with literal checks; the LAT=0 instance is
    // optionally pinned at its cycle-1 ACCESS.
    task automatic xfer(string nm, logic r, logic w, word_t a, word_t s,
                        word_t exp_ld, logic chk0);
        word_t rd;
        rd = w ? 32'h0 : exp_ld;
        drive(r, w, a, s);
        cyc();
        lit({nm, "_c1"}, 0, BUSY, 0);
        if (chk0) lit({nm, "_lat0_c1"}, 1, ACCESS, rd);
        cyc();
        lit({nm, "_c2"}, 0, BUSY, 0);
        cyc();
        lit({nm, "_c3"}, 0, ACCESS, rd);
        cyc();
        drive(0, 0, 0, 0);
        lit({nm, "_c4"}, 0, FREE, 0);
        cyc();
        cyc();
    endtask

    task automatic err_case(string nm, logic r, logic w, word_t a);
        drive(r, w, a, 0);
        cyc();
        drive(0, 0, 0, 0);
        lit({nm, "_c1"}, 0, ERROR, 32'hBAD1BAD1);
        lit({nm, "_lat0_c1"}, 1, ERROR, 32'hBAD1BAD1);
        cyc();
        lit({nm, "_c2"}, 0, FREE, 0);
        cyc();
    endtask

    initial begin
        drive(0, 0, 0, 0);
        repeat (3) @(posedge CLK);
        #3;
        nRST = 1'b1;
        lit("rst", 0, FREE, 0);
        lit("rst_lat0", 1, FREE, 0);
        cyc();

        xfer("rd40", 1, 0, 32'h40, 0, 32'h0, 1);
        xfer("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 1);
        xfer("rd10", 1, 0, 32'h10, 0, 32'hDEADBEEF, 1);

        drive(1, 0, 32'h20, 0);
        cyc();
        lit("abt_c1", 0, BUSY, 0);
        cyc();
        drive(1, 0, 32'h24, 0);
        lit("abt_c2", 0, BUSY, 0);
        cyc();
        lit("abt_c3", 0, FREE, 0);
        cyc();
        lit("abt_c4", 0, BUSY, 0);
        cyc();
        cyc();
        lit("abt_c6", 0, ACCESS, 0);
        cyc();
        drive(0, 0, 0, 0);
        lit("abt_c7", 0, FREE, 0);
        cyc();
        cyc();

        xfer("wr30", 0, 1, 32'h30, 32'h11111111, 32'h0, 1);
        drive(0, 1, 32'h30, 32'h22222222);
        cyc();
        lit("wab_c1", 0, BUSY, 0);
        cyc();
        drive(0, 0, 0, 0);
        lit("wab_c2", 0, BUSY, 0);
        cyc();
        lit("wab_c3", 0, FREE, 0);
        cyc();
        cyc();
        xfer("rd30", 1, 0, 32'h30, 0, 32'h11111111, 0);

        err_case("err_rw", 1, 1, 32'h0);
        err_case("err_mis", 1, 0, 32'h3);
        err_case("err_oob", 1, 0, 32'(MW * 4));

        drive(0, 1, 32'h8, 32'h12345678);
        cyc();
        cyc();
        cyc();
        lit("rmw_c3", 0, ACCESS, 0);
        nRST = 1'b0;
        #1;
        lit("rmw_rst", 0, FREE, 0);
        lit("rmw_rst_lat0", 1, FREE, 0);
        drive(0, 0, 0, 0);
        cyc();
        nRST = 1'b1;
        cyc();

        xfer("rd08", 1, 0, 32'h8, 0, 32'h0, 1);
        xfer("rd10_clr", 1, 0, 32'h10, 0, 32'h0, 1);
        xfer("wr10_b", 0, 1, 32'h10, 32'hCAFEF00D, 32'h0, 1);
        xfer("rd10_b", 1, 0, 32'h10, 0, 32'hCAFEF00D, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
